ifft4_seq: RTL and testbench

- 4-point floating-point (IEEE-754 single) inverse FFT; the return path for the 4-point forward FFT. Sits after frequency-domain processing and hands time-domain samples back to the datapath.
- Iterative: a single rad2_bf butterfly is time-shared over 4 butterfly cycles (2 stages × 2), followed by a 1/N scaling cycle.
- Valid/ready handshakes on input and output. Natural-order input and output.

---
 rtl/ifft4_seq_if.sv | 25 ++
 rtl/ifft4_seq.sv | 179 +++++++++++++++++
 tb/tb_ifft4_seq.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/ifft4_seq_if.sv
// Frame handshake bundle for the 4-point inverse FFT: packed complex input,
// forward twiddles, and the packed time-domain result.
interface ifft4_seq_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] A_r;
  logic [127:0] A_i;
  logic [63:0]  W_r;
  logic [63:0]  W_i;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] C_r;
  logic [127:0] C_i;
  logic         Exception;

  modport master (
    output in_valid, A_r, A_i, W_r, W_i, out_ready,
    input  in_ready, out_valid, C_r, C_i, Exception
  );

  modport slave (
    input  in_valid, A_r, A_i, W_r, W_i, out_ready,
    output in_ready, out_valid, C_r, C_i, Exception
  );
endinterface

// File: rtl/ifft4_seq.sv
// Iterative 4-point single-precision inverse FFT: one time-shared radix-2
// butterfly over four cycles, then a 1/N exponent scaling cycle.
module ifft4_seq (
  input logic        clk,
  input logic        rst_n,
  ifft4_seq_if.slave bus
);
  localparam int          NUM_P     = 4;
  localparam logic [7:0]  EXP_SCALE = 8'($clog2(NUM_P));
  localparam logic [31:0] QNAN      = 32'h7FC00000;

  typedef enum logic [2:0] {IDLE, S1_0, S1_1, S2_0, S2_1, SCALE, OUT} state_t;
  state_t state, state_nxt;

  logic [3:0][31:0] yr, yi, c_r, c_i;
  logic [31:0] sh_r, sh_i, w0r, w0i, w1r, w1i;
  logic        exc;
  logic [31:0] ar, ai, br, bi, wr, wi, tr, ti, bp_r, bp_i, bm_r, bm_i;
  logic        bf_exc, scale_exc;

  // Round-to-nearest-even on a normalised significand; flush on underflow.
  function automatic logic [31:0] pack_rne(input logic s, input logic signed [9:0] e,
                                           input logic [22:0] f, input logic g, input logic st);
    logic [23:0]       fr;
    logic signed [9:0] er;
    fr = {1'b0, f} + {23'd0, g & (st | f[0])};
    er = e + $signed({9'd0, fr[23]});
    if (er >= 10'sd255) return {s, 8'hFF, 23'd0};
    if (er <= 10'sd0)   return {s, 31'd0};
    return {s, er[7:0], fr[22:0]};
  endfunction

  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    logic              s;
    logic [47:0]       pr;
    logic signed [9:0] e;
    s = a[31] ^ b[31];
    if ((&a[30:23] && |a[22:0]) || (&b[30:23] && |b[22:0])) return QNAN;
    if (&a[30:23] || &b[30:23]) begin
      if (~|a[30:23] || ~|b[30:23]) return QNAN;
      return {s, 8'hFF, 23'd0};
    end
    if (~|a[30:23] || ~|b[30:23]) return {s, 31'd0};
    pr = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
    e  = $signed({2'b00, a[30:23]}) + $signed({2'b00, b[30:23]}) - 10'sd126;
    if (!pr[47]) begin
      pr = pr << 1;
      e  = e - 10'sd1;
    end
    return pack_rne(s, e, pr[46:24], pr[23], |pr[22:0]);
  endfunction

  // Subnormal operands are treated as zero; exact cancellation gives +0.
  function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
    logic [31:0]       x, y;
    logic [7:0]        d;
    logic [26:0]       mx, my;
    logic [27:0]       sm;
    logic signed [9:0] e;
    if ((&a[30:23] && |a[22:0]) || (&b[30:23] && |b[22:0])) return QNAN;
    if (&a[30:23] && &b[30:23]) return (a[31] == b[31]) ? a : QNAN;
    if (&a[30:23]) return a;
    if (&b[30:23]) return b;
    if (~|a[30:23] && ~|b[30:23]) return {a[31] & b[31], 31'd0};
    if (~|a[30:23]) return b;
    if (~|b[30:23]) return a;
    if (a[30:0] >= b[30:0]) begin x = a; y = b; end
    else                    begin x = b; y = a; end
    d  = x[30:23] - y[30:23];
    mx = {1'b1, x[22:0], 3'b000};
    my = {1'b1, y[22:0], 3'b000};
    if (d > 8'd26) my = 27'd1;
    else           my = (my >> d) | {26'd0, |(my & ~({27{1'b1}} << d))};
    e = $signed({2'b00, x[30:23]});
    if (x[31] == y[31]) begin
      sm = {1'b0, mx} + {1'b0, my};
      if (sm[27]) begin
        sm = {1'b0, sm[27:2], sm[1] | sm[0]};
        e  = e + 10'sd1;
      end
    end else begin
      sm = {1'b0, mx} - {1'b0, my};
      if (sm == 28'd0) return 32'd0;
      for (int i = 0; i < 26; i++) begin
        if (!sm[26]) begin
          sm = sm << 1;
          e  = e - 10'sd1;
        end
      end
    end
    return pack_rne(x[31], e, sm[25:3], sm[2], |sm[1:0]);
  endfunction

  function automatic logic [31:0] scale_word(input logic [31:0] v);
    if (&v[30:23])             return v;
    if (v[30:23] <= EXP_SCALE) return {v[31], 31'd0};
    return {v[31], v[30:23] - EXP_SCALE, v[22:0]};
  endfunction

  // Butterfly operand select; S1_1 takes the pre-stage copy of y1.
  always_comb begin
    ar = '0; ai = '0; br = '0; bi = '0; wr = w0r; wi = w0i;
    unique case (state)
      S1_0:    begin ar = yr[0]; ai = yi[0]; br = yr[2]; bi = yi[2]; end
      S1_1:    begin ar = sh_r;  ai = sh_i;  br = yr[3]; bi = yi[3]; end
      S2_0:    begin ar = yr[0]; ai = yi[0]; br = yr[2]; bi = yi[2]; end
      S2_1:    begin ar = yr[1]; ai = yi[1]; br = yr[3]; bi = yi[3]; wr = w1r; wi = w1i; end
      default: ;
    endcase
    tr     = fadd(fmul(wr, br), fmul(wi, bi) ^ 32'h80000000);
    ti     = fadd(fmul(wr, bi), fmul(wi, br));
    bp_r   = fadd(ar, tr);
    bp_i   = fadd(ai, ti);
    bm_r   = fadd(ar, tr ^ 32'h80000000);
    bm_i   = fadd(ai, ti ^ 32'h80000000);
    bf_exc = &bp_r[30:23] | &bp_i[30:23] | &bm_r[30:23] | &bm_i[30:23];
    scale_exc = 1'b0;
    for (int k = 0; k < NUM_P; k++) scale_exc = scale_exc | &yr[k][30:23] | &yi[k][30:23];
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (bus.in_valid) state_nxt = S1_0;
      S1_0:    state_nxt = S1_1;
      S1_1:    state_nxt = S2_0;
      S2_0:    state_nxt = S2_1;
      S2_1:    state_nxt = SCALE;
      SCALE:   state_nxt = OUT;
      OUT:     if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      yr <= '0; yi <= '0; c_r <= '0; c_i <= '0;
      sh_r <= '0; sh_i <= '0; w0r <= '0; w0i <= '0; w1r <= '0; w1i <= '0;
      exc <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (bus.in_valid) begin
          yr   <= bus.A_r;
          yi   <= bus.A_i;
          sh_r <= bus.A_r[63:32];
          sh_i <= bus.A_i[63:32];
          w0r  <= bus.W_r[31:0];
          w1r  <= bus.W_r[63:32];
          w0i  <= {~bus.W_i[31], bus.W_i[30:0]};
          w1i  <= {~bus.W_i[63], bus.W_i[62:32]};
          exc  <= 1'b0;
        end
        S1_0: begin yr[0] <= bp_r; yi[0] <= bp_i; yr[1] <= bm_r; yi[1] <= bm_i; exc <= exc | bf_exc; end
        S1_1: begin yr[2] <= bp_r; yi[2] <= bp_i; yr[3] <= bm_r; yi[3] <= bm_i; exc <= exc | bf_exc; end
        S2_0: begin yr[0] <= bp_r; yi[0] <= bp_i; yr[2] <= bm_r; yi[2] <= bm_i; exc <= exc | bf_exc; end
        S2_1: begin yr[1] <= bp_r; yi[1] <= bp_i; yr[3] <= bm_r; yi[3] <= bm_i; exc <= exc | bf_exc; end
        SCALE: begin
          for (int k = 0; k < NUM_P; k++) begin
            c_r[k] <= scale_word(yr[k]);
            c_i[k] <= scale_word(yi[k]);
          end
          exc <= exc | scale_exc;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == OUT);
  assign bus.C_r       = c_r;
  assign bus.C_i       = c_i;
  assign bus.Exception = exc;
endmodule

// File: tb/tb_ifft4_seq.sv
// Directed bench for ifft4_seq: hand-computed 4-point inverse transforms,
// handshake latency, backpressure, scaling corner cases and mid-frame reset.
module tb_ifft4_seq;
  localparam logic [31:0] ONE  = 32'h3F800000;
  localparam logic [31:0] FOUR = 32'h40800000;
  localparam logic [31:0] NEG1 = 32'hBF800000;
  localparam logic [31:0] Z    = 32'h00000000;
  localparam logic [63:0] W_R  = {Z, ONE};      // W1 = 0 - j, W0 = 1 + 0j
  localparam logic [63:0] W_I  = {NEG1, Z};

  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   lat;
  logic [127:0] hold_r, hold_i;

  ifft4_seq_if bus ();
  ifft4_seq dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [127:0] pk(input logic [31:0] x3, input logic [31:0] x2,
                                      input logic [31:0] x1, input logic [31:0] x0);
    return {x3, x2, x1, x0};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge with in_ready high; returns at the falling edge after acceptance.
  task automatic send(input logic [127:0] ar, input logic [127:0] ai);
    bus.A_r = ar; bus.A_i = ai; bus.W_r = W_R; bus.W_i = W_I;
    bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic frame(input string tag, input logic [127:0] ar, input logic [127:0] ai);
    send(ar, ai);
    lat = 1;
    while (!bus.out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_latency"}, 128'(lat), 128'd6);
  endtask

  task automatic release_hs(input string tag);
    @(negedge clk);
    chk({tag, "_in_ready_after"}, 128'(bus.in_ready), 128'd1);
    chk({tag, "_out_valid_after"}, 128'(bus.out_valid), 128'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    bus.A_r = '0; bus.A_i = '0; bus.W_r = '0; bus.W_i = '0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 128'(bus.in_ready), 128'd1);
    chk("rst_out_valid", 128'(bus.out_valid), 128'd0);
    chk("rst_C_r", bus.C_r, '0);
    chk("rst_C_i", bus.C_i, '0);
    chk("rst_exc", 128'(bus.Exception), 128'd0);
    rst_n = 1'b1;
    @(negedge clk);

    frame("dc", pk(Z, Z, Z, FOUR), '0);
    chk("dc_C_r", bus.C_r, pk(ONE, ONE, ONE, ONE));
    chk("dc_C_i", bus.C_i, '0);
    chk("dc_exc", 128'(bus.Exception), 128'd0);
    release_hs("dc");

    frame("flat", pk(ONE, ONE, ONE, ONE), '0);
    chk("flat_C_r", bus.C_r, pk(Z, Z, Z, ONE));
    chk("flat_C_i", bus.C_i, '0);
    release_hs("flat");

    frame("conj", pk(Z, Z, FOUR, Z), '0);
    chk("conj_C_r", bus.C_r, pk(Z, NEG1, Z, ONE));
    chk("conj_C_i", bus.C_i, pk(NEG1, Z, ONE, Z));
    release_hs("conj");

    // Backpressure: result held, a waiting frame must not be taken.
    bus.out_ready = 1'b0;
    frame("bp", pk(Z, Z, FOUR, Z), '0);
    hold_r = bus.C_r;
    hold_i = bus.C_i;
    chk("bp_C_r", hold_r, pk(Z, NEG1, Z, ONE));
    bus.A_r = pk(ONE, ONE, ONE, ONE);
    bus.in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_hold_valid", 128'(bus.out_valid), 128'd1);
      chk("bp_hold_ready", 128'(bus.in_ready), 128'd0);
      chk("bp_hold_C_r", bus.C_r, hold_r);
      chk("bp_hold_C_i", bus.C_i, hold_i);
      chk("bp_hold_exc", 128'(bus.Exception), 128'd0);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    release_hs("bp");
    chk("bp_C_r_kept", bus.C_r, hold_r);
    repeat (3) @(negedge clk);
    chk("bp_no_extra_frame", 128'(bus.out_valid), 128'd0);

    frame("flush", pk(Z, Z, Z, 32'h01000000), '0);
    chk("flush_C_r", bus.C_r, '0);
    chk("flush_C_i", bus.C_i, '0);
    chk("flush_exc", 128'(bus.Exception), 128'd0);
    release_hs("flush");

    frame("nan", pk(Z, Z, Z, 32'h7FC00000), '0);
    chk("nan_exc", 128'(bus.Exception), 128'd1);
    release_hs("nan");

    frame("clean", pk(Z, Z, Z, FOUR), '0);
    chk("clean_exc", 128'(bus.Exception), 128'd0);
    chk("clean_C_r", bus.C_r, pk(ONE, ONE, ONE, ONE));
    release_hs("clean");

    // Reset while the frame sits in S2_0.
    send(pk(Z, Z, Z, FOUR), '0);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 128'(bus.out_valid), 128'd0);
    chk("mid_rst_in_ready", 128'(bus.in_ready), 128'd1);
    chk("mid_rst_C_r", bus.C_r, '0);
    chk("mid_rst_C_i", bus.C_i, '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_no_output", 128'(bus.out_valid), 128'd0);
    frame("post_rst", pk(Z, Z, Z, FOUR), '0);
    chk("post_rst_C_r", bus.C_r, pk(ONE, ONE, ONE, ONE));
    chk("post_rst_C_i", bus.C_i, '0);
    chk("post_rst_exc", 128'(bus.Exception), 128'd0);
    release_hs("post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
